// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and the data-memory responder.
// The master side issues accesses; the slave side answers and reports stall/count.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic [15:0] access_count;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall, access_count
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall, access_count
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word-addressed data memory: accept, wait LATENCY cycles, access, respond.
// Misaligned or out-of-range addresses fault without touching storage.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic [CNT_W-1:0]   waitCnt;
    logic [CNT_W-1:0]   waitCntNext;
    logic               accept;
    logic               doAccess;

    logic               latWe;
    logic [31:0]        latAddr;
    logic [31:0]        latWdata;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [IDX_W-1:0]   wordIdx;
    logic               fault;

    logic               rspValid;
    logic               rspErr;
    logic [31:0]        rspRdata;
    logic [15:0]        accessCount;

    assign wordIdx = latAddr[IDX_W+1:2];
    assign fault   = (latAddr[1:0] != 2'b00) || (latAddr[31:2] >= 30'(DEPTH_WORDS));

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
        end
    end

    // Next-state logic; the access fires on the edge where the counter reads 1
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        accept      = 1'b0;
        doAccess    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept      = 1'b1;
                    stateNext   = WAIT;
                    waitCntNext = CNT_W'(LATENCY);
                end
            end
            WAIT: begin
                if (waitCnt == CNT_W'(1)) begin
                    doAccess    = 1'b1;
                    stateNext   = RESP;
                    waitCntNext = '0;
                end else begin
                    waitCntNext = waitCnt - CNT_W'(1);
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Request is captured once at accept so later bus changes cannot leak in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latWe    <= 1'b0;
            latAddr  <= '0;
            latWdata <= '0;
        end else if (accept) begin
            latWe    <= bus.req_we;
            latAddr  <= bus.req_addr;
            latWdata <= bus.req_wdata;
        end
    end

    // Storage survives reset
    always_ff @(posedge clk) begin
        if (doAccess && !fault && latWe) begin
            mem[wordIdx] <= latWdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rspValid    <= 1'b0;
            rspErr      <= 1'b0;
            rspRdata    <= '0;
            accessCount <= '0;
        end else begin
            rspValid <= doAccess;
            if (doAccess) begin
                if (fault) begin
                    rspErr   <= 1'b1;
                    rspRdata <= '0;
                end else begin
                    rspErr   <= 1'b0;
                    rspRdata <= latWe ? latWdata : mem[wordIdx];
                    if (accessCount != 16'hFFFF) begin
                        accessCount <= accessCount + 16'd1;
                    end
                end
            end
        end
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.stall        = (state == WAIT) || ((state == IDLE) && bus.req_valid);
    assign bus.rsp_valid    = rspValid;
    assign bus.rsp_rdata    = rspRdata;
    assign bus.rsp_err      = rspErr;
    assign bus.access_count = accessCount;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (LATENCY=2, DEPTH_WORDS=256) with a queue-based
// scoreboard: requests push expected responses, a monitor pops on every rsp_valid.
module tb_dmem_responder;
    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] cnt;
    } expT;

    logic clk;
    logic rst_n;
    int   nChecks = 0;
    int   nFails  = 0;
    expT  expQ[$];
    bit   stallPat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                expT e;
                e = expQ.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                check("access_count", 32'(bus.access_count), 32'(e.cnt));
            end
        end
    end

    // One access; bus inputs are scrambled during WAIT to prove the request was latched
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expRdata, input logic expErr, input logic [15:0] expCnt);
        int budget;
        int cyc;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        budget = 0;
        while (bus.req_ready !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 20) check("ready_timeout", 32'd1, 32'd0);
        expQ.push_back('{rdata: expRdata, err: expErr, cnt: expCnt});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = ~we;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = ~wdata;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.rsp_valid !== 1'b1 && cyc < 20);
        check("rsp_latency", 32'(cyc), 32'd3);
    endtask

    task automatic holdTest();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0;
        expQ.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, cnt: 16'd7});
        #1 check("stall_0", 32'(bus.stall), 32'(stallPat[0]));
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            if (k == 3) begin
                check("ready_in_resp", 32'(bus.req_ready), 32'd0);
                bus.req_we    = 1'b1;
                bus.req_addr  = 32'h14;
                bus.req_wdata = 32'h0BADF00D;
                expQ.push_back('{rdata: 32'h0BADF00D, err: 1'b0, cnt: 16'd8});
            end
            if (k == 4) check("ready_after_resp", 32'(bus.req_ready), 32'd1);
            if (k == 5) begin
                bus.req_addr  = 32'h3;
                bus.req_wdata = 32'h0;
            end
            #1 check($sformatf("stall_%0d", k), 32'(bus.stall), 32'(stallPat[k]));
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_access_count", 32'(bus.access_count), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_stall", 32'(bus.stall), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(1'b1, 32'h10,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 16'd1);
        issue(1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 16'd2);
        issue(1'b0, 32'h13,  32'h0,        32'h0,        1'b1, 16'd2);
        issue(1'b1, 32'h0,   32'h12345678, 32'h12345678, 1'b0, 16'd3);
        issue(1'b1, 32'h400, 32'hAAAAAAAA, 32'h0,        1'b1, 16'd3);
        issue(1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0, 16'd4);
        issue(1'b1, 32'h3FC, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 16'd5);
        issue(1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, 16'd6);

        holdTest();
        issue(1'b0, 32'h14,  32'h0,        32'h0BADF00D, 1'b0, 16'd9);
        issue(1'b1, 32'h20,  32'h11111111, 32'h11111111, 1'b0, 16'd10);

        // Abort a store with reset in its first WAIT cycle
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'h55;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("abort_access_count", 32'(bus.access_count), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        issue(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 16'd1);

        // Saturation from a forced count
        @(negedge clk);
        force dut.accessCount = 16'hFFFB;
        #1 release dut.accessCount;
        issue(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 16'hFFFC);
        issue(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 16'hFFFD);
        issue(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 16'hFFFE);
        issue(1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 16'hFFFF);
        issue(1'b1, 32'h24, 32'h7777, 32'h7777,  1'b0, 16'hFFFF);
        issue(1'b0, 32'h24, 32'h0,  32'h7777,    1'b0, 16'hFFFF);
        issue(1'b0, 32'h21, 32'h0,  32'h0,       1'b1, 16'hFFFF);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words (power of two, 4..4096).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the wait cycles between accept and response (1..15).
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port req_valid  input  1  memory-stage access request present.
REQ-006 Port req_we  input  1  1 = store, 0 = load.
REQ-007 Port req_addr  input  32  byte address.
REQ-008 Port req_wdata  input  32  store data.
REQ-009 Port req_ready  output  1  request can be accepted this cycle.
REQ-010 Port rsp_valid  output  1  one-cycle response pulse.
REQ-011 Port rsp_rdata  output  32  load data, or written data for stores.
REQ-012 Port rsp_err  output  1  access faulted, qualified by rsp_valid.
REQ-013 Port stall  output  1  hold request to the pipeline hazard logic.
REQ-014 Port access_count  output  16  completed non-faulting accesses, saturating.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 Accept occurs on a rising edge with req_valid=1 in IDLE: latch req_we, req_addr and req_wdata, load the wait counter with LATENCY, and go to WAIT.
REQ-018 The latched request SHALL be used until the response; req_* changes or req_valid deassertion during WAIT SHALL be ignored.
REQ-019 In WAIT the counter SHALL decrement each cycle; on the edge where it equals 1 the FSM SHALL perform the access and go to RESP, so WAIT lasts exactly LATENCY cycles.
REQ-020 A fault SHALL be decided at that edge: req_addr[1:0]!=0 or word index req_addr[31:2] >= DEPTH_WORDS.
REQ-021 Faulting access: no storage write, rsp_err=1, rsp_rdata=0, access_count unchanged.
REQ-022 Good load: rsp_rdata SHALL be storage[req_addr[31:2]] registered at that edge; rsp_err=0.
REQ-023 Good store: storage[index] SHALL be written with req_wdata at that edge; rsp_rdata SHALL equal req_wdata; rsp_err=0.
REQ-024 In RESP, rsp_valid SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE unconditionally, with no response backpressure.
REQ-025 rsp_rdata and rsp_err SHALL hold their last values until the next response.
REQ-026 stall SHALL be combinational: 1 when state=WAIT, or state=IDLE and req_valid=1; 0 in RESP.
REQ-027 A request present during RESP SHALL NOT be accepted; it is accepted in the following IDLE cycle, giving back-to-back throughput of one access per LATENCY+2 cycles.
REQ-028 access_count SHALL increment on each non-faulting access edge and saturate at 16'hFFFF without wrapping.
REQ-029 Accept-to-rsp_valid latency SHALL be LATENCY+1 cycles, with rsp_valid high in cycle LATENCY+1 after the accept edge.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0 and access_count 0, with no clock required.
REQ-031 Reset during WAIT SHALL abort the request with no storage write and no response.
REQ-032 Storage contents SHALL NOT be cleared by reset.
REQ-033 The first accept SHALL be possible on the first rising edge after rst_n rises.

Verification (LATENCY=2, DEPTH_WORDS=256)
REQ-034 Store then load:
- store addr 0x10, data 0xDEADBEEF -> rsp_valid 3 cycles after accept, rsp_rdata 0xDEADBEEF.
- load 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, access_count 2.
REQ-035 Faults:
- load 0x13 -> rsp_err 1, rsp_rdata 0, access_count unchanged.
- store 0x400 -> rsp_err 1; a subsequent load of 0x0 returns its prior value.
REQ-036 Hold and ignore:
- req_valid held high across two requests -> stall pattern 1,1,1,0,1,...
- second request accepted only in the IDLE cycle after RESP.
- changing req_addr during WAIT does not alter the response.
REQ-037 Reset abort:
- assert rst_n=0 in the first WAIT cycle of a store of 0x55 to 0x20 -> no rsp_valid, rsp_rdata 0.
- after reset, load 0x20 returns the pre-reset contents.
REQ-038 Saturation:
- preload access_count to 0xFFFE via 3 good accesses from a forced state, or via 65534 good accesses.
- 3 further good accesses -> access_count stays 0xFFFF.
